// File: rtl/calc_requester_pkg.sv
// Shared constants and types for the calculator requester: ALU modes,
// opcodes, response status bit positions and the requester FSM states.
package calc_requester_pkg;

  // ALU mode selection
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_FLOAT = 1'b1;

  // Operation codes understood by the calculator
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  // Bit positions inside rsp_status = {timeout, div_by_zero, underflow, overflow}
  localparam int STAT_OVERFLOW    = 0;
  localparam int STAT_UNDERFLOW   = 1;
  localparam int STAT_DIV_BY_ZERO = 2;
  localparam int STAT_TIMEOUT     = 3;

  // Requester FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } req_state_e;

  // Assemble the response status word from individual flags
  function automatic logic [3:0] pack_status(input logic timeout,
                                             input logic div_by_zero,
                                             input logic underflow,
                                             input logic overflow);
    logic [3:0] status;
    status                   = 4'b0000;
    status[STAT_TIMEOUT]     = timeout;
    status[STAT_DIV_BY_ZERO] = div_by_zero;
    status[STAT_UNDERFLOW]   = underflow;
    status[STAT_OVERFLOW]    = overflow;
    return status;
  endfunction

endpackage

// File: rtl/calc_requester.sv
// Calculator requester: accepts one command, launches it on the calculator
// with a single start pulse, waits (bounded) for done, then presents a
// response until it is consumed. All outputs come straight from flops.
module calc_requester
  import calc_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  // command side
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  // calculator side
  output logic [31:0]      calc_a,
  output logic [31:0]      calc_b,
  output logic [3:0]       calc_op,
  output logic             calc_mode,
  output logic             calc_start,
  input  logic [31:0]      calc_result,
  input  logic             calc_done,
  input  logic             calc_overflow,
  input  logic             calc_underflow,
  input  logic             calc_div_by_zero,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_status,
  output logic [TAG_W-1:0] rsp_tag
);

  // One spare bit above what the limit needs so the count can never wrap
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  req_state_e       state_q,      state_d;
  logic             cmd_ready_q,  cmd_ready_d;
  logic [31:0]      calc_a_q,     calc_a_d;
  logic [31:0]      calc_b_q,     calc_b_d;
  logic [3:0]       calc_op_q,    calc_op_d;
  logic             calc_mode_q,  calc_mode_d;
  logic             calc_start_q, calc_start_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_status_q, rsp_status_d;
  logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    calc_a_d     = calc_a_q;
    calc_b_d     = calc_b_q;
    calc_op_d    = calc_op_q;
    calc_mode_d  = calc_mode_q;
    calc_start_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    rsp_tag_d    = rsp_tag_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          calc_a_d     = cmd_a;
          calc_b_d     = cmd_b;
          calc_op_d    = cmd_op;
          calc_mode_d  = cmd_mode;
          rsp_tag_d    = cmd_tag;
          cmd_ready_d  = 1'b0;
          // registered, so the pulse is visible exactly during ISSUE
          calc_start_d = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          cmd_ready_d  = 1'b1;
        end
      end

      ST_ISSUE: begin
        wait_cnt_d = CNT_ZERO;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (calc_done) begin
          // done has priority even on the cycle the limit is reached
          rsp_result_d = calc_result;
          rsp_status_d = pack_status(1'b0, calc_div_by_zero,
                                     calc_underflow, calc_overflow);
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else if (wait_cnt_q == CNT_LIMIT) begin
          rsp_result_d = 32'd0;
          rsp_status_d = pack_status(1'b1, 1'b0, 1'b0, 1'b0);
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          wait_cnt_d   = wait_cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          // cmd_ready rises only after this handshake cycle
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      calc_a_q     <= 32'd0;
      calc_b_q     <= 32'd0;
      calc_op_q    <= 4'd0;
      calc_mode_q  <= 1'b0;
      calc_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_status_q <= 4'd0;
      rsp_tag_q    <= {TAG_W{1'b0}};
      wait_cnt_q   <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      calc_a_q     <= calc_a_d;
      calc_b_q     <= calc_b_d;
      calc_op_q    <= calc_op_d;
      calc_mode_q  <= calc_mode_d;
      calc_start_q <= calc_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
      rsp_tag_q    <= rsp_tag_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign calc_a     = calc_a_q;
  assign calc_b     = calc_b_q;
  assign calc_op    = calc_op_q;
  assign calc_mode  = calc_mode_q;
  assign calc_start = calc_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;
  assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_calc_requester.sv
// Self-checking bench for calc_requester: a behavioural calculator stub with
// programmable done delay (pulse or level), directed corner cases and a
// randomized transaction loop checked against an end-to-end response model.
module tb_calc_requester;
  import calc_requester_pkg::*;

  localparam int T     = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a, cmd_b;
  logic [3:0]       cmd_op;
  logic             cmd_mode;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      calc_a, calc_b;
  logic [3:0]       calc_op;
  logic             calc_mode;
  logic             calc_start;
  logic [31:0]      calc_result;
  logic             calc_done;
  logic             calc_overflow, calc_underflow, calc_div_by_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_status;
  logic [TAG_W-1:0] rsp_tag;

  int errors = 0;
  int checks = 0;

  calc_requester #(.TIMEOUT_CYCLES(T), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_mode(calc_mode),
    .calc_start(calc_start), .calc_result(calc_result), .calc_done(calc_done),
    .calc_overflow(calc_overflow), .calc_underflow(calc_underflow),
    .calc_div_by_zero(calc_div_by_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_status(rsp_status), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  // Arithmetic behaviour of the calculator: returns {dbz, unf, ovf, result}
  function automatic logic [34:0] calc_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [32:0] s;
    logic [63:0] p;
    logic        dbz, unf, ovf;
    logic [31:0] res;
    dbz = 1'b0; unf = 1'b0; ovf = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; res = s[31:0]; ovf = s[32]; end
      OP_SUB: begin res = a - b; unf = (a < b); end
      OP_MUL: begin p = {32'd0, a} * {32'd0, b}; res = p[31:0]; ovf = (p[63:32] != 32'd0); end
      OP_DIV: begin
        if (b == 32'd0) begin res = 32'd0; dbz = 1'b1; end
        else res = a / b;
      end
      default: res = a ^ b;
    endcase
    return {dbz, unf, ovf, res};
  endfunction

  // Calculator stub: done appears m_delay cycles after the start cycle
  // (m_delay <= 0 means never); level mode keeps done high until next start
  int         m_delay = 0;
  bit         m_level = 1'b0;
  bit         m_busy;
  int         m_rem;
  logic [2:0] m_flags;
  assign {calc_div_by_zero, calc_underflow, calc_overflow} = m_flags;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_rem <= 0; calc_done <= 1'b0;
      calc_result <= 32'd0; m_flags <= 3'b000;
    end else if (calc_start) begin
      {m_flags, calc_result} <= calc_fn(calc_a, calc_b, calc_op);
      m_busy    <= (m_delay > 1);
      m_rem     <= m_delay - 1;
      calc_done <= (m_delay == 1);
    end else if (m_busy) begin
      if (m_rem == 1) begin calc_done <= 1'b1; m_busy <= 1'b0; end
      else m_rem <= m_rem - 1;
    end else if (!m_level) begin
      calc_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_calc"}, {calc_a, calc_b, calc_op, calc_mode, calc_start}, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_result, rsp_status, rsp_tag}, 0);
  endtask

  // One full command/response transaction; called just after a negedge
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic mode, input logic [3:0] tag, input int delay,
                         input bit level, input int hold);
    logic [34:0] ref_v;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
    logic [67:0] rsp_snap;
    int exp_lat, k, starts;
    bit seen;
    ref_v = calc_fn(a, b, op);
    if (delay >= 1 && delay <= T) begin
      exp_res = ref_v[31:0]; exp_st = {1'b0, ref_v[34:32]}; exp_lat = delay + 2;
    end else begin
      exp_res = 32'd0; exp_st = 4'b1000; exp_lat = T + 2;
    end
    m_delay = delay; m_level = level;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_mode = mode; cmd_tag = tag;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 4'($urandom);
    cmd_mode = ~mode; cmd_tag = ~tag;
    chk("issue_start", calc_start, 1);
    chk("issue_cmd_ready", cmd_ready, 0);
    chk("issue_operands", {calc_a, calc_b, calc_op, calc_mode}, {a, b, op, mode});
    starts = 1; seen = 1'b0; k = 1;
    while (!seen && k < T + 8) begin
      @(negedge clk);
      k++;
      chk("calc_hold", {calc_a, calc_b, calc_op, calc_mode, cmd_ready}, {a, b, op, mode, 1'b0});
      if (rsp_valid) seen = 1'b1;
      else if (calc_start) starts++;
    end
    chk("rsp_seen", seen, 1);
    chk("latency", k, exp_lat);
    chk("start_pulses", starts, 1);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_status", rsp_status, exp_st);
    chk("rsp_tag", rsp_tag, tag);
    rsp_snap = {rsp_result, rsp_status, rsp_tag, 28'd0};
    // backpressure with a competing command that must not be taken
    cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_rsp_stable", {rsp_valid, rsp_result, rsp_status, rsp_tag, 28'd0}, {1'b1, rsp_snap});
      chk("bp_no_accept", {cmd_ready, calc_start}, 0);
    end
    rsp_ready = 1'b1;
    chk("hs_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("post_hs", {rsp_valid, cmd_ready, calc_start}, 3'b010);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int rd;
    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = 32'd0; cmd_b = 32'd0; cmd_op = 4'd0; cmd_mode = 1'b0; cmd_tag = 4'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // first accept on the first edge after release; fixed add
    run_txn(32'd5, 32'd7, OP_ADD, MODE_FIXED, 4'd3, 2, 1'b0, 0);
    chk("add_exact", {rsp_result, rsp_status}, {32'd12, 4'b0000});
    // divide by zero with level done (stays high into next ISSUE)
    run_txn(32'd9, 32'd0, OP_DIV, MODE_FIXED, 4'd5, 1, 1'b1, 1);
    // timeout: never done, float mode
    run_txn(32'h1234, 32'h10, OP_MUL, MODE_FLOAT, 4'd7, 0, 1'b0, 2);
    // done exactly on the last WAIT cycle wins
    run_txn(32'hFFFF_FFFF, 32'd2, OP_ADD, MODE_FIXED, 4'd9, T, 1'b0, 0);
    // done one cycle too late -> timeout
    run_txn(32'd3, 32'd8, OP_SUB, MODE_FLOAT, 4'd11, T + 1, 1'b0, 0);
    // long backpressure
    run_txn(32'd100, 32'd7, OP_DIV, MODE_FIXED, 4'd12, 3, 1'b0, 10);

    // reset while waiting
    m_delay = 0; m_level = 1'b0;
    cmd_valid = 1'b1; cmd_a = 32'd1; cmd_b = 32'd2; cmd_op = OP_ADD; cmd_tag = 4'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("reset_wait");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", {rsp_valid, calc_start, cmd_ready}, 3'b001);
    end
    // reset during ISSUE drops calc_start without waiting for a clock
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("issue_before_reset", calc_start, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("reset_issue");
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(32'd20, 32'd22, OP_ADD, MODE_FIXED, 4'd1, 2, 1'b0, 0);

    // randomized traffic
    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      rd = $urandom_range(0, T + 2);
      run_txn(ra, rb, 4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), rd, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_requester.md
CALC_REQUESTER -- requirements
Module: calc_requester

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles spent waiting for calc_done.
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the width of the command tag.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_a, cmd_b  input  32 each  operands.
REQ-009 cmd_op  input  4  operation code.
REQ-010 cmd_mode  input  1  ALU mode: 0=fixed, 1=float.
REQ-011 cmd_tag  input  TAG_W  requester tag, echoed in the response.
REQ-012 calc_a, calc_b  output  32 each  operands to the calculator.
REQ-013 calc_op  output  4  operation code to the calculator.
REQ-014 calc_mode  output  1  ALU mode to the calculator.
REQ-015 calc_start  output  1  one-cycle start pulse to the calculator.
REQ-016 calc_result  input  32  result from the calculator.
REQ-017 calc_done, calc_overflow, calc_underflow, calc_div_by_zero  input  1 each  calculator status.
REQ-018 rsp_valid  output  1  response present.
REQ-019 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-020 rsp_result  output  32  captured result.
REQ-021 rsp_status  output  4  status flags {timeout, div_by_zero, underflow, overflow}.
REQ-022 rsp_tag  output  TAG_W  echoed command tag.

Function
REQ-023 The block SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-024 cmd_ready SHALL be 1 only in IDLE.
REQ-025 On a cmd_valid&&cmd_ready handshake, the block SHALL register a/b/op/mode/tag onto the calc_* and rsp_tag outputs and move to ISSUE.
REQ-026 In ISSUE, calc_start SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-027 calc_a, calc_b, calc_op and calc_mode SHALL hold stable from ISSUE until the return to IDLE.
REQ-028 calc_done SHALL be ignored outside WAIT.
REQ-029 Both level and pulse forms of done are valid; the first WAIT cycle with calc_done=1 SHALL capture calc_result and the three flags into rsp_*, clear the timeout bit, and move to RESP.
REQ-030 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without done.
REQ-031 If the counter reaches TIMEOUT_CYCLES-1 without done, the block SHALL set rsp_result=0 and rsp_status=4'b1000 and move to RESP.
REQ-032 If done arrives in the same cycle the limit is reached, done SHALL win: no timeout is reported.
REQ-033 In RESP, rsp_valid SHALL be 1, with rsp_* held stable until rsp_ready; on the handshake the FSM SHALL return to IDLE.
REQ-034 cmd_ready SHALL not rise in the same cycle as the RESP handshake; the next command is accepted one cycle later at the earliest.
REQ-035 Minimum command-to-response latency SHALL be 3 cycles: accept, ISSUE, WAIT with done, then rsp_valid high.
REQ-036 The counter SHALL be sized as $clog2(TIMEOUT_CYCLES)+1 bits and SHALL not wrap.

Reset
REQ-037 While reset_n=0, the FSM SHALL be in IDLE and every output SHALL be 0, except cmd_ready, which SHALL be 1.
REQ-038 Reset asserted mid-operation, in any state, SHALL abort immediately with no response; calc_start SHALL drop asynchronously.
REQ-039 The first accept after reset release SHALL be possible on the first rising edge with reset_n=1.

Structure
REQ-040 MODE_FIXED/MODE_FLOAT, the opcode constants and the status bit indices SHALL live in common/alu_defines.v.
REQ-041 The block SHALL be a single module with no sub-modules.
REQ-042 The top-level integration SHALL connect calc_* to the calculator top's operand_a, operand_b, operation, alu_mode, start, result, done and flag ports.

Verification
REQ-043 Fixed add: a=5, b=7, op=ADD, mode=0, tag=3, calculator model done after 2 cycles -> one calc_start pulse; rsp_result=12, rsp_status=0, rsp_tag=3.
REQ-044 Divide by zero: a=9, b=0, op=DIV, model returns div_by_zero=1 -> rsp_status=4'b0100.
REQ-045 Timeout: float mode, model never asserts done -> exactly TIMEOUT_CYCLES WAIT cycles, then rsp_status=4'b1000 and rsp_result=0.
REQ-046 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_* stable and cmd_ready=0 throughout; a second cmd_valid is not accepted.
REQ-047 Reset in WAIT: assert reset_n=0 -> all outputs 0 and cmd_ready=1; no rsp_valid afterwards; a new command completes normally.
REQ-048 Done on timeout edge: done asserted at counter=TIMEOUT_CYCLES-1 -> normal result reported with the timeout bit 0.
